xy_move_sequencer: RTL
======================

XY_MOVE_SEQUENCER -- requirements
Module: xy_move_sequencer

Interface
REQ-001 Parameter STEP_PERIOD, default 5000000, clock cycles between consecutive step ticks (minimum 2).
REQ-002 Parameter DW, default 12, width of signed move-command fields.
REQ-003 clk_100mhz  in  1  system clock; all state on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  in  1  move command offered.
REQ-006 cmd_ready  out  1  sequencer can accept a command.
REQ-007 cmd_dx  in  DW  signed x displacement in full steps.
REQ-008 cmd_dy  in  DW  signed y displacement in full steps.
REQ-009 abort  in  1  stop the current move at the next clock edge.
REQ-010 coil_en  in  1  1 = drive coils; 0 = force both coil outputs to 4'b0000.
REQ-011 coil_x  out  4  x-axis driver pattern {A+,A-,B+,B-}.
REQ-012 coil_y  out  4  y-axis driver pattern {A+,A-,B+,B-}.
REQ-013 busy  out  1  high in LOAD and RUN.
REQ-014 done  out  1  one-cycle pulse at move completion or abort.
REQ-015 pos_x  out  16  signed x step position, wraps mod 2^16.
REQ-016 pos_y  out  16  signed y step position, wraps mod 2^16.

Function
REQ-017 Phase table: phase 0=1010, 1=0110, 2=0101, 3=1001; coil_x/coil_y are registered from the per-axis 2-bit phase, gated by coil_en; phase is kept while coil_en=0.
REQ-018 A positive step increments the phase mod 4 (3->0) and pos by 1. A negative step decrements the phase mod 4 (0->3) and pos by 1.
REQ-019 States are IDLE, LOAD, RUN and DONE; cmd_ready=1 only in IDLE.
REQ-020 IDLE: when cmd_valid&&cmd_ready, latch cmd_dx/cmd_dy; go to LOAD. If both are 0, go to DONE instead.
REQ-021 LOAD, one cycle: compute magnitudes |dx|,|dy| as DW-bit unsigned (-2^(DW-1) is legal); compute direction bits; major=max(|dx|,|dy|), minor=min; err=major>>1 (DW+1 bits); tick counter=0; remaining=major; go to RUN.
REQ-022 RUN: the tick counter counts 0..STEP_PERIOD-1, and a tick fires on the cycle it equals STEP_PERIOD-1. The first tick is STEP_PERIOD cycles after entering RUN.
REQ-023 On each tick:
- The major axis steps. On a tie |dx|=|dy|, x is major.
- err+=minor; if the result is >=major, the minor axis steps and err-=major.
- remaining decrements.
REQ-024 After the tick that makes remaining 0, go to DONE; exactly |dx| x-steps and |dy| y-steps occur.
REQ-025 An axis with zero displacement never steps.
REQ-026 abort in LOAD or RUN: go to DONE on the next edge. Steps already taken stand. A tick coinciding with abort is not applied.
REQ-027 abort in IDLE or DONE is ignored.
REQ-028 DONE: done=1 for one cycle, then IDLE. A command offered during DONE is not accepted until IDLE.
REQ-029 Command accepted at cycle N: busy=1 from N+1. For a zero command, done=1 at N+1.

Reset
REQ-030 rst asserted, asynchronously: IDLE, phases 0, coil_x=coil_y=4'b1010 (if coil_en=1), pos_x=pos_y=0, busy=0, done=0, cmd_ready=1 after release, counters and err 0.
REQ-031 rst mid-move discards the move with no done pulse; the first edge after deassertion may accept a command.

Verification (bench STEP_PERIOD=4)
REQ-032 Reset with coil_en=1 -> coil_x=coil_y=1010, pos=0, cmd_ready=1; set coil_en=0 -> coils 0000; restore -> 1010.
REQ-033 dx=+3, dy=0 -> coil_x 0110, 0101, 1001 at ticks 1-3; pos_x=3; coil_y unchanged; done pulse once; back to IDLE.
REQ-034 dx=4, dy=-2 -> x steps every tick; y steps at ticks 1 and 3 only; final pos=(4,-2); coil_x=1010, coil_y=0101.
REQ-035 dx=0, dy=0 -> done one cycle after accept; no coil or pos change; busy stays 0.
REQ-036 dx=10 with abort after tick 2 -> pos_x=2, coil_x=0101, done pulse, cmd_ready=1; next dx=-2 -> pos_x=0.
REQ-037 cmd_valid held high through a move -> exactly one accept until IDLE. A second command is then accepted. rst mid-move -> pos=0, phases 0, no done.

Source files
------------

// File: rtl/xy_move_sequencer.sv
// Two-axis stepper move sequencer: accepts a signed (dx,dy) full-step command and
// walks both coils along a Bresenham line, one major-axis step per tick.
module xy_move_sequencer #(
    parameter int STEP_PERIOD = 5000000,
    parameter int DW          = 12
) (
    input  logic                 clk_100mhz,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic signed [DW-1:0] cmd_dx,
    input  logic signed [DW-1:0] cmd_dy,
    input  logic                 abort,
    input  logic                 coil_en,
    output logic [3:0]           coil_x,
    output logic [3:0]           coil_y,
    output logic                 busy,
    output logic                 done,
    output logic signed [15:0]   pos_x,
    output logic signed [15:0]   pos_y
);
    localparam int CW = $clog2(STEP_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(STEP_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] dx_q, dy_q;
    logic          dir_x, dir_y;      // 1 = negative direction
    logic          x_major;
    logic [DW-1:0] major, minor, remaining;
    logic [DW:0]   err;
    logic [CW-1:0] cnt;
    logic [1:0]    phase_x, phase_y;

    logic [DW-1:0] abs_x, abs_y, major_c, minor_c;
    logic [DW:0]   err_sum;
    logic          tick, minor_step, step_x, step_y;
    logic [1:0]    phase_x_nxt, phase_y_nxt;

    function automatic logic [3:0] phase_pat(input logic [1:0] p);
        case (p)
            2'd0:    phase_pat = 4'b1010;
            2'd1:    phase_pat = 4'b0110;
            2'd2:    phase_pat = 4'b0101;
            default: phase_pat = 4'b1001;
        endcase
    endfunction

    // Magnitudes as unsigned DW bits so the most negative command is still exact.
    assign abs_x   = dx_q[DW-1] ? DW'(-dx_q) : dx_q;
    assign abs_y   = dy_q[DW-1] ? DW'(-dy_q) : dy_q;
    assign major_c = (abs_x >= abs_y) ? abs_x : abs_y;
    assign minor_c = (abs_x >= abs_y) ? abs_y : abs_x;

    assign tick        = (state == RUN) && (cnt == LAST) && !abort;
    assign err_sum     = err + {1'b0, minor};
    assign minor_step  = err_sum >= {1'b0, major};
    assign step_x      = tick && (x_major || minor_step);
    assign step_y      = tick && (!x_major || minor_step);
    assign phase_x_nxt = step_x ? phase_x + (dir_x ? 2'd3 : 2'd1) : phase_x;
    assign phase_y_nxt = step_y ? phase_y + (dir_y ? 2'd3 : 2'd1) : phase_y;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == LOAD) || (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cmd_valid)
                      state_nxt = (cmd_dx == '0 && cmd_dy == '0) ? DONE : LOAD;
            LOAD: state_nxt = abort ? DONE : RUN;
            RUN:  if (abort || (tick && remaining == DW'(1)))
                      state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            dx_q      <= '0;
            dy_q      <= '0;
            dir_x     <= 1'b0;
            dir_y     <= 1'b0;
            x_major   <= 1'b1;
            major     <= '0;
            minor     <= '0;
            remaining <= '0;
            err       <= '0;
            cnt       <= '0;
            phase_x   <= 2'd0;
            phase_y   <= 2'd0;
            pos_x     <= '0;
            pos_y     <= '0;
            coil_x    <= 4'b1010;
            coil_y    <= 4'b1010;
        end else begin
            if (state == IDLE && cmd_valid) begin
                dx_q <= cmd_dx;
                dy_q <= cmd_dy;
            end
            if (state == LOAD) begin
                dir_x     <= dx_q[DW-1];
                dir_y     <= dy_q[DW-1];
                x_major   <= abs_x >= abs_y;
                major     <= major_c;
                minor     <= minor_c;
                remaining <= major_c;
                err       <= {1'b0, major_c >> 1};
                cnt       <= '0;
            end else if (state == RUN && !abort) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            if (tick) begin
                err       <= minor_step ? err_sum - {1'b0, major} : err_sum;
                remaining <= remaining - 1'b1;
            end
            if (step_x) pos_x <= dir_x ? pos_x - 16'sd1 : pos_x + 16'sd1;
            if (step_y) pos_y <= dir_y ? pos_y - 16'sd1 : pos_y + 16'sd1;
            phase_x <= phase_x_nxt;
            phase_y <= phase_y_nxt;
            // Phase keeps advancing with coils gated off; only the driven pattern is forced low.
            coil_x  <= coil_en ? phase_pat(phase_x_nxt) : 4'b0000;
            coil_y  <= coil_en ? phase_pat(phase_y_nxt) : 4'b0000;
        end
    end
endmodule
